// File: rtl/micro_sequencer_pkg.sv
// Shared microword layout, COND encodings and sequencer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package micro_sequencer_pkg;

  localparam int MICROSEQ_ADDR_W = 11;
  localparam int MICROSEQ_WORD_W = 41;

  // Field widths, MSB to LSB; the packed struct below fixes the bit positions.
  localparam int A_W     = 6;
  localparam int B_W     = 6;
  localparam int C_W     = 6;
  localparam int ALU_W   = 4;
  localparam int COND_W  = 3;
  localparam int JADDR_W = MICROSEQ_ADDR_W;

  localparam logic DECODE_PREFIX = 1'b1;

  typedef enum logic [COND_W-1:0] {
    COND_NEXT   = 3'b000,
    COND_N      = 3'b001,
    COND_Z      = 3'b010,
    COND_V      = 3'b011,
    COND_C      = 3'b100,
    COND_IR13   = 3'b101,
    COND_JUMP   = 3'b110,
    COND_DECODE = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [A_W-1:0]     a;
    logic               amux;
    logic [B_W-1:0]     b;
    logic               bmux;
    logic [C_W-1:0]     c;
    logic               cmux;
    logic               rd;
    logic               wr;
    logic [ALU_W-1:0]   alu;
    cond_e              cond;
    logic [JADDR_W-1:0] jaddr;
  } mword_t;

endpackage

// File: rtl/micro_next_addr.sv
// Next-microaddress selection from COND, JADDR, PSR flags and IR fields.
// Latency: purely combinational.
// Backpressure: none.
module micro_next_addr
  import micro_sequencer_pkg::*;
(
  input  logic [MICROSEQ_ADDR_W-1:0] csai,
  input  cond_e                      cond,
  input  logic [JADDR_W-1:0]         jaddr,
  input  logic [3:0]                 flags,
  input  logic [1:0]                 ir_op,
  input  logic [5:0]                 ir_op3,
  input  logic                       ir_bit13,
  output logic [MICROSEQ_ADDR_W-1:0] next_addr
);

  logic [MICROSEQ_ADDR_W-1:0] csai_inc;

  // Natural width wrap gives 2047 -> 0.
  assign csai_inc = csai + 1'b1;

  always_comb begin
    next_addr = csai_inc;
    case (cond)
      COND_NEXT:   next_addr = csai_inc;
      COND_N:      next_addr = flags[3] ? jaddr : csai_inc;
      COND_Z:      next_addr = flags[2] ? jaddr : csai_inc;
      COND_V:      next_addr = flags[1] ? jaddr : csai_inc;
      COND_C:      next_addr = flags[0] ? jaddr : csai_inc;
      COND_IR13:   next_addr = ir_bit13 ? jaddr : csai_inc;
      COND_JUMP:   next_addr = jaddr;
      COND_DECODE: next_addr = {DECODE_PREFIX, ir_op, ir_op3, 2'b00};
      default:     next_addr = csai_inc;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: CSAI/MIR registers, ROM addressing, memory-stall FSM (optional MICROSEQ_SINGLESTEP_EN).
// Latency: one microinstruction per clock; ROM address is combinational from MIR/CSAI/flags/IR.
// Backpressure: holds MIR/CSAI while a RD/WR waits for MemReady (and, with single-step, while Step_In=0).
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter logic [MICROSEQ_ADDR_W-1:0] MICROSEQ_RESET_ADDR = 11'd0
) (
  input  logic                       MICROSEQ_CLOCK_50,
  input  logic                       MICROSEQ_RESET_InLow,
  output logic [MICROSEQ_ADDR_W-1:0] MICROSEQ_ROMAddr_Out,
  input  logic [MICROSEQ_WORD_W-1:0] MICROSEQ_ROMData_In,
  input  logic [31:0]                MICROSEQ_IR_In,
  input  logic [3:0]                 MICROSEQ_Flags_In,
`ifdef MICROSEQ_SINGLESTEP_EN
  input  logic                       MICROSEQ_Step_In,
`endif
  input  logic                       MICROSEQ_MemReady_In,
  output logic [MICROSEQ_WORD_W-1:0] MICROSEQ_MIR_Out,
  output logic                       MICROSEQ_MIRValid_Out,
  output logic [MICROSEQ_ADDR_W-1:0] MICROSEQ_CSAI_Out
);

  state_e                     state_q, state_d;
  mword_t                     mir_q;
  logic                       mir_valid_q;
  logic [MICROSEQ_ADDR_W-1:0] csai_q, csai_d;
  logic [MICROSEQ_ADDR_W-1:0] next_addr;
  logic                       load;
  logic                       mem_ok;
  logic                       step_ok;
  logic                       unused_ir;

`ifdef MICROSEQ_SINGLESTEP_EN
  assign step_ok = MICROSEQ_Step_In;
`else
  assign step_ok = 1'b1;
`endif

  // IR bits outside op/op3/bit13 are not consumed by sequencing.
  assign unused_ir = ^{MICROSEQ_IR_In[29:25], MICROSEQ_IR_In[18:14], MICROSEQ_IR_In[12:0]};

  assign mem_ok = !(mir_q.rd || mir_q.wr) || MICROSEQ_MemReady_In;

  micro_next_addr u_next_addr (
    .csai      (csai_q),
    .cond      (mir_q.cond),
    .jaddr     (mir_q.jaddr),
    .flags     (MICROSEQ_Flags_In),
    .ir_op     (MICROSEQ_IR_In[31:30]),
    .ir_op3    (MICROSEQ_IR_In[24:19]),
    .ir_bit13  (MICROSEQ_IR_In[13]),
    .next_addr (next_addr)
  );

  always_comb begin
    state_d              = state_q;
    load                 = 1'b0;
    csai_d               = csai_q;
    MICROSEQ_ROMAddr_Out = next_addr;
    case (state_q)
      BOOT: begin
        MICROSEQ_ROMAddr_Out = MICROSEQ_RESET_ADDR;
        load                 = 1'b1;
        csai_d               = MICROSEQ_RESET_ADDR;
        state_d              = RUN;
      end
      RUN: begin
        if (!mem_ok) begin
          state_d = WAIT;
        end else if (step_ok) begin
          load   = 1'b1;
          csai_d = next_addr;
        end
      end
      WAIT: begin
        if (mem_ok && step_ok) begin
          load    = 1'b1;
          csai_d  = next_addr;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge MICROSEQ_CLOCK_50 or negedge MICROSEQ_RESET_InLow) begin
    if (!MICROSEQ_RESET_InLow) begin
      state_q     <= BOOT;
      mir_q       <= '0;
      mir_valid_q <= 1'b0;
      csai_q      <= MICROSEQ_RESET_ADDR;
    end else begin
      state_q <= state_d;
      if (load) begin
        mir_q       <= MICROSEQ_ROMData_In;
        csai_q      <= csai_d;
        mir_valid_q <= 1'b1;
      end
    end
  end

  assign MICROSEQ_MIR_Out      = mir_q;
  assign MICROSEQ_MIRValid_Out = mir_valid_q;
  assign MICROSEQ_CSAI_Out     = csai_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a small microprogram in a bench-side ROM,
// walked by a vector table plus a reset-during-stall sequence.
module tb_micro_sequencer;

  logic        clk;
  logic        rst_n;
  logic [10:0] rom_addr;
  logic [40:0] rom_data;
  logic [31:0] ir;
  logic [3:0]  flags;
  logic        mem_ready;
  logic [40:0] mir;
  logic        mir_valid;
  logic [10:0] csai;
`ifdef MICROSEQ_SINGLESTEP_EN
  logic        step;
`endif

  logic [40:0] rom [0:2047];
  int          errors = 0;
  int          checks = 0;

  micro_sequencer dut (
    .MICROSEQ_CLOCK_50     (clk),
    .MICROSEQ_RESET_InLow  (rst_n),
    .MICROSEQ_ROMAddr_Out  (rom_addr),
    .MICROSEQ_ROMData_In   (rom_data),
    .MICROSEQ_IR_In        (ir),
    .MICROSEQ_Flags_In     (flags),
`ifdef MICROSEQ_SINGLESTEP_EN
    .MICROSEQ_Step_In      (step),
`endif
    .MICROSEQ_MemReady_In  (mem_ready),
    .MICROSEQ_MIR_Out      (mir),
    .MICROSEQ_MIRValid_Out (mir_valid),
    .MICROSEQ_CSAI_Out     (csai)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  // Microword: A field carries a tag so every ROM word is distinguishable.
  function automatic logic [40:0] mw(input logic [5:0] tag, input logic rd, input logic wr,
                                     input logic [2:0] cond, input logic [10:0] jaddr);
    return {tag, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, rd, wr, 4'd0, cond, jaddr};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive inputs, check ROM address, clock once, check registers.
  task automatic cyc(input logic [31:0] v_ir, input logic [3:0] v_flags, input logic v_mrdy,
                     input logic [10:0] exp_rom, input logic [10:0] exp_csai);
    ir        = v_ir;
    flags     = v_flags;
    mem_ready = v_mrdy;
    #1;
    chk("rom_addr", 64'(rom_addr), 64'(exp_rom));
    @(posedge clk);
    #1;
    chk("csai", 64'(csai), 64'(exp_csai));
    chk("mir", 64'(mir), 64'(rom[exp_csai]));
    chk("mir_valid", 64'(mir_valid), 64'd1);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] ir;
    logic [3:0]  flags;
    logic        mrdy;
    logic [10:0] exp_rom;
    logic [10:0] exp_csai;
  } vec_t;

  vec_t vecs [16];

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = '0;
    rom[0]    = mw(6'd1, 1'b0, 1'b0, 3'b110, 11'd8);     // jump 8
    rom[8]    = mw(6'd2, 1'b0, 1'b0, 3'b010, 11'd12);    // branch on z
    rom[9]    = mw(6'd3, 1'b0, 1'b0, 3'b100, 11'd8);     // branch on c
    rom[12]   = mw(6'd4, 1'b0, 1'b0, 3'b111, 11'd0);     // decode
    rom[1792] = mw(6'd5, 1'b0, 1'b0, 3'b101, 11'd1794);  // branch on IR[13]
    rom[1793] = mw(6'd6, 1'b0, 1'b0, 3'b110, 11'd1792);
    rom[1794] = mw(6'd7, 1'b0, 1'b1, 3'b111, 11'd0);     // write + decode
    rom[1600] = mw(6'd8, 1'b1, 1'b0, 3'b110, 11'd2047);  // read, jump 2047
    rom[2047] = mw(6'd9, 1'b0, 1'b0, 3'b000, 11'd5);     // sequential wrap

    //          ir            flags    mrdy  rom      csai
    vecs[0]  = '{32'h0,        4'b0000, 1'b1, 11'd0,    11'd0};     // BOOT
    vecs[1]  = '{32'h0,        4'b0000, 1'b1, 11'd8,    11'd8};
    vecs[2]  = '{32'h0,        4'b0000, 1'b1, 11'd9,    11'd9};     // z=0
    vecs[3]  = '{32'h0,        4'b0001, 1'b1, 11'd8,    11'd8};     // c=1
    vecs[4]  = '{32'h0,        4'b0100, 1'b1, 11'd12,   11'd12};    // z=1
    vecs[5]  = '{32'hC000_0000, 4'b0000, 1'b1, 11'd1792, 11'd1792}; // op=11 op3=0
    vecs[6]  = '{32'h0,        4'b0000, 1'b1, 11'd1793, 11'd1793}; // IR13=0
    vecs[7]  = '{32'h0,        4'b0000, 1'b1, 11'd1792, 11'd1792};
    vecs[8]  = '{32'h0000_2000, 4'b0000, 1'b1, 11'd1794, 11'd1794}; // IR13=1
    vecs[9]  = '{32'h8080_0000, 4'b0000, 1'b1, 11'd1600, 11'd1600}; // WR ready, op=10 op3=010000
    vecs[10] = '{32'h0,        4'b0000, 1'b0, 11'd2047, 11'd1600}; // RD stall
    vecs[11] = '{32'h0,        4'b0000, 1'b0, 11'd2047, 11'd1600};
    vecs[12] = '{32'h0,        4'b0000, 1'b0, 11'd2047, 11'd1600};
    vecs[13] = '{32'h0,        4'b0000, 1'b1, 11'd2047, 11'd2047}; // released
    vecs[14] = '{32'h0,        4'b0000, 1'b1, 11'd0,    11'd0};     // 2047 -> 0
    vecs[15] = '{32'h0,        4'b0000, 1'b1, 11'd8,    11'd8};

    rst_n     = 1'b0;
    ir        = '0;
    flags     = '0;
    mem_ready = 1'b1;
`ifdef MICROSEQ_SINGLESTEP_EN
    step      = 1'b1;
`endif
    #12;
    chk("reset mir", 64'(mir), 64'd0);
    chk("reset mir_valid", 64'(mir_valid), 64'd0);
    chk("reset csai", 64'(csai), 64'd0);
    chk("reset rom_addr", 64'(rom_addr), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc(vecs[i].ir, vecs[i].flags, vecs[i].mrdy, vecs[i].exp_rom, vecs[i].exp_csai);
    end

    // Walk into a read stall, then assert reset asynchronously mid-cycle.
    cyc(32'h0,         4'b0100, 1'b1, 11'd12,   11'd12);
    cyc(32'h8080_0000, 4'b0000, 1'b1, 11'd1600, 11'd1600);
    cyc(32'h0,         4'b0000, 1'b0, 11'd2047, 11'd1600);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async reset mir", 64'(mir), 64'd0);
    chk("async reset mir_valid", 64'(mir_valid), 64'd0);
    chk("async reset csai", 64'(csai), 64'd0);
    chk("async reset rom_addr", 64'(rom_addr), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    cyc(32'h0, 4'b0000, 1'b0, 11'd0, 11'd0);  // BOOT restart ignores MemReady
    cyc(32'h0, 4'b0000, 1'b1, 11'd8, 11'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
